// File: rtl/bin_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : bin_seq_pkg
// Shared types and width helpers for the bin request sequencer.
// Rev     : 1.0
// ============================================================================
package bin_seq_pkg;

    // Widest per-command bin count carried through the command buffer.
    // CNT_W of the sequencer must not exceed this.
    localparam int CMD_CNT_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]               pstate;
        logic                     bypass;
        logic [CMD_CNT_MAX_W-1:0] num_bins;
    } cmd_t;

    function automatic int nb_width(input int bin_width);
        return (bin_width > 1) ? $clog2(bin_width) : 1;
    endfunction

    function automatic int out_cnt_width(input int out_w);
        return $clog2(out_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_request_sequencer_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : cmd_fifo
// Synchronous FIFO with full/empty flags; depth must be a power of two.
// Rev    : 1.0
// ============================================================================
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bin_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module : bin_request_sequencer
// Buffers decode commands, drives the Decoder bin controls, packs bins into words.
// Rev    : 1.0
// ============================================================================
module bin_request_sequencer
    import bin_seq_pkg::*;
#(
    parameter  int BIN_WIDTH  = 4,
    parameter  int CNT_W      = 7,
    parameter  int FIFO_DEPTH = 4,
    parameter  int OUT_W      = 8,
    localparam int NB_W       = nb_width(BIN_WIDTH),
    localparam int OCW        = out_cnt_width(OUT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_pstate,
    input  logic             cmd_bypass,
    input  logic [CNT_W-1:0] cmd_num_bins,
    output logic             dec_en,
    output logic [7:0]       dec_pstate,
    output logic             dec_bypass,
    output logic [NB_W-1:0]  dec_n_bin,
    input  logic             dec_stall,
    input  logic [BIN_WIDTH-1:0] dec_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [OCW-1:0]   out_count,
    output logic             out_last
);

    localparam int RW = CMD_CNT_MAX_W;

    state_t              state_q, state_d;
    cmd_t                act_q, act_d;
    cmd_t                cmd_in, cmd_head;
    logic [OCW-1:0]      fill_q, fill_d;
    logic [OUT_W-1:0]    acc_q, acc_d, acc_next;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic [OCW-1:0]      out_count_q, out_count_d;
    logic                out_last_q, out_last_d;
    logic                alive_q;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [OCW-1:0]      k, fill_sum;
    logic [BIN_WIDTH-1:0] bin_mask;
    logic                fire, last, emit;

    // Held low through reset and released one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) alive_q <= 1'b0;
        else       alive_q <= 1'b1;
    end

    assign cmd_ready = alive_q && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    always_comb begin
        cmd_in          = '0;
        cmd_in.pstate   = cmd_pstate;
        cmd_in.bypass   = cmd_bypass;
        cmd_in.num_bins = RW'(cmd_num_bins);
    end

    cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (cmd_in),
        .pop     (fifo_pop),
        .rd_data (cmd_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Bins this cycle; forced to 1 when no bins remain so dec_n_bin never wraps.
    always_comb begin
        if (!act_q.bypass || act_q.num_bins == '0) begin
            k = OCW'(1);
        end else if (32'(act_q.num_bins) < 32'(BIN_WIDTH)) begin
            k = OCW'(act_q.num_bins);
        end else begin
            k = OCW'(BIN_WIDTH);
        end
        for (int i = 0; i < BIN_WIDTH; i++) begin
            bin_mask[i] = (32'(i) < 32'(k));
        end
        fill_sum = fill_q + k;
        last     = (act_q.num_bins == RW'(k));
        emit     = last || (fill_sum == OCW'(OUT_W));
        acc_next = acc_q | (OUT_W'(dec_bin & bin_mask) << fill_q);
        dec_en   = (state_q == RUN) && (!out_valid_q || out_ready);
        fire     = dec_en && !dec_stall;
    end

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        fill_d      = fill_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        fifo_pop    = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    act_d    = cmd_head;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                state_d = (act_q.num_bins == '0) ? IDLE : RUN;
            end
            RUN: begin
                if (fire) begin
                    act_d.num_bins = act_q.num_bins - RW'(k);
                    if (emit) begin
                        // Accumulator is cleared so the next word starts with zero upper bits.
                        fill_d      = '0;
                        acc_d       = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = acc_next;
                        out_count_d = fill_sum;
                        out_last_d  = last;
                        if (last) state_d = IDLE;
                    end else begin
                        fill_d = fill_sum;
                        acc_d  = acc_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            act_q       <= '0;
            fill_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            fill_q      <= fill_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
        end
    end

    assign dec_pstate = act_q.pstate;
    assign dec_bypass = act_q.bypass;
    assign dec_n_bin  = NB_W'(k - OCW'(1));
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_count  = out_count_q;
    assign out_last   = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_request_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_bin_request_sequencer
// Directed self-checking bench for bin_request_sequencer (BIN_WIDTH=4, OUT_W=8).
// Rev    : 1.0
// ============================================================================
module tb_bin_request_sequencer;

    localparam int BIN_WIDTH  = 4;
    localparam int CNT_W      = 7;
    localparam int FIFO_DEPTH = 4;
    localparam int OUT_W      = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_pstate = '0;
    logic             cmd_bypass = 1'b0;
    logic [CNT_W-1:0] cmd_num_bins = '0;
    logic             dec_en;
    logic [7:0]       dec_pstate;
    logic             dec_bypass;
    logic [1:0]       dec_n_bin;
    logic             dec_stall = 1'b0;
    logic [BIN_WIDTH-1:0] dec_bin = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_data;
    logic [3:0]       out_count;
    logic             out_last;

    int total = 0;
    int bad   = 0;

    logic        bin_src[$];
    logic [31:0] got_nb[$], got_ps[$], got_wd[$], got_wc[$], got_wl[$];
    logic [31:0] exp_nb[$], exp_ps[$], exp_wd[$], exp_wc[$], exp_wl[$];

    logic [7:0]       f_ps [6];
    logic             f_byp[6];
    logic [CNT_W-1:0] f_nb [6];

    bin_request_sequencer #(
        .BIN_WIDTH  (BIN_WIDTH),
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .OUT_W      (OUT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_pstate   (cmd_pstate),
        .cmd_bypass   (cmd_bypass),
        .cmd_num_bins (cmd_num_bins),
        .dec_en       (dec_en),
        .dec_pstate   (dec_pstate),
        .dec_bypass   (dec_bypass),
        .dec_n_bin    (dec_n_bin),
        .dec_stall    (dec_stall),
        .dec_bin      (dec_bin),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bits(input logic [31:0] value, input int n);
        for (int i = 0; i < n; i++) bin_src.push_back(value[i]);
    endtask

    task automatic expect_fire(input logic [31:0] nb, input logic [31:0] ps);
        exp_nb.push_back(nb);
        exp_ps.push_back(ps);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [31:0] c, input logic [31:0] l);
        exp_wd.push_back(d);
        exp_wc.push_back(c);
        exp_wl.push_back(l);
    endtask

    task automatic clear_queues();
        got_nb.delete(); got_ps.delete(); got_wd.delete(); got_wc.delete(); got_wl.delete();
        exp_nb.delete(); exp_ps.delete(); exp_wd.delete(); exp_wc.delete(); exp_wl.delete();
        bin_src.delete();
    endtask

    // Decoder model for one cycle: supplies bins on every fire and logs accepted words.
    task automatic run_cycle(input logic stall, input logic ordy);
        dec_stall = stall;
        out_ready = ordy;
        dec_bin   = '0;
        #1;
        if (out_valid && out_ready) begin
            got_wd.push_back(32'(out_data));
            got_wc.push_back(32'(out_count));
            got_wl.push_back(32'(out_last));
        end
        if (dec_en && !dec_stall) begin
            got_nb.push_back(32'(dec_n_bin));
            got_ps.push_back(32'(dec_pstate));
            for (int i = 0; i <= int'(dec_n_bin) && i < BIN_WIDTH; i++) begin
                dec_bin[i] = (bin_src.size() > 0) ? bin_src.pop_front() : 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] ps, input logic byp, input logic [CNT_W-1:0] nb);
        int n = 0;
        cmd_pstate   = ps;
        cmd_bypass   = byp;
        cmd_num_bins = nb;
        cmd_valid    = 1'b1;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic start_cmd(input logic [7:0] ps, input logic byp, input logic [CNT_W-1:0] nb);
        send_cmd(ps, byp, nb);
        step();
        step();
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_nfire"}, 32'(got_nb.size()), 32'(exp_nb.size()));
        for (int i = 0; i < exp_nb.size() && i < got_nb.size(); i++) begin
            chk($sformatf("%s_nbin%0d", tag, i), got_nb[i], exp_nb[i]);
            chk($sformatf("%s_pstate%0d", tag, i), got_ps[i], exp_ps[i]);
        end
        chk({tag, "_nword"}, 32'(got_wd.size()), 32'(exp_wd.size()));
        for (int i = 0; i < exp_wd.size() && i < got_wd.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_wd[i], exp_wd[i]);
            chk($sformatf("%s_count%0d", tag, i), got_wc[i], exp_wc[i]);
            chk($sformatf("%s_last%0d", tag, i), got_wl[i], exp_wl[i]);
        end
        chk({tag, "_bins_left"}, 32'(bin_src.size()), 32'd0);
        clear_queues();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepted;
        int seen;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dec_en", 32'(dec_en), 32'd0);
        chk("rst_outputs", 32'({out_data, out_count, out_last, dec_pstate, dec_bypass, dec_n_bin}), 32'd0);
        reset = 1'b0;
        step();
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // ---------------- regular command, with latency ----------------
        push_bits(32'h5, 3);
        send_cmd(8'h25, 1'b0, 7'd3);
        chk("lat_pop", 32'(dec_en), 32'd0);
        step();
        chk("lat_load", 32'(dec_en), 32'd0);
        step();
        chk("lat_run", 32'(dec_en), 32'd1);
        chk("reg_bypass", 32'(dec_bypass), 32'd0);
        repeat (6) run_cycle(1'b0, 1'b1);
        repeat (3) expect_fire(32'd0, 32'h25);
        expect_word(32'h05, 32'd3, 32'd1);
        compare_all("regular");
        chk("reg_idle_dec_en", 32'(dec_en), 32'd0);

        // ---------------- bypass command ----------------
        push_bits(32'h3FF, 10);
        start_cmd(8'h10, 1'b1, 7'd10);
        chk("byp_bypass", 32'(dec_bypass), 32'd1);
        repeat (8) run_cycle(1'b0, 1'b1);
        expect_fire(32'd3, 32'h10);
        expect_fire(32'd3, 32'h10);
        expect_fire(32'd1, 32'h10);
        expect_word(32'hFF, 32'd8, 32'd0);
        expect_word(32'h03, 32'd2, 32'd1);
        compare_all("bypass");

        // ---------------- decoder stall mid-command ----------------
        push_bits(32'h4D, 8);
        push_bits(32'h3, 2);
        start_cmd(8'h10, 1'b1, 7'd10);
        run_cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            dec_stall = 1'b1;
            #1;
            chk($sformatf("stall_dec_en%0d", i), 32'(dec_en), 32'd1);
            chk($sformatf("stall_nbin%0d", i), 32'(dec_n_bin), 32'd3);
            chk($sformatf("stall_pstate%0d", i), 32'(dec_pstate), 32'h10);
            step();
        end
        repeat (8) run_cycle(1'b0, 1'b1);
        expect_fire(32'd3, 32'h10);
        expect_fire(32'd3, 32'h10);
        expect_fire(32'd1, 32'h10);
        expect_word(32'h4D, 32'd8, 32'd0);
        expect_word(32'h03, 32'd2, 32'd1);
        compare_all("stall");

        // ---------------- output backpressure ----------------
        push_bits(32'hA5, 8);
        push_bits(32'h3C, 8);
        push_bits(32'h9, 4);
        start_cmd(8'h11, 1'b1, 7'd20);
        repeat (4) run_cycle(1'b0, 1'b0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_dec_en", 32'(dec_en), 32'd0);
        chk("bp_data", 32'(out_data), 32'hA5);
        chk("bp_count", 32'(out_count), 32'd8);
        step();
        chk("bp_data_stable", 32'(out_data), 32'hA5);
        chk("bp_last_stable", 32'(out_last), 32'd0);
        repeat (10) run_cycle(1'b0, 1'b1);
        repeat (5) expect_fire(32'd3, 32'h11);
        expect_word(32'hA5, 32'd8, 32'd0);
        expect_word(32'h3C, 32'd8, 32'd0);
        expect_word(32'h09, 32'd4, 32'd1);
        compare_all("backpressure");

        // ---------------- command buffer fill, zero-length command ----------------
        f_ps  = '{8'h40, 8'h30, 8'h41, 8'h42, 8'h43, 8'h44};
        f_byp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        f_nb  = '{7'd2, 7'd0, 7'd1, 7'd5, 7'd2, 7'd3};
        push_bits(32'h1, 2);
        push_bits(32'h1, 1);
        push_bits(32'h16, 5);
        push_bits(32'h3, 2);
        dec_stall = 1'b1;
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid    = 1'b1;
            cmd_pstate   = f_ps[i];
            cmd_bypass   = f_byp[i];
            cmd_num_bins = f_nb[i];
            #1;
            if (cmd_ready) accepted++;
            step();
        end
        cmd_valid = 1'b0;
        chk("fifo_accepted", 32'(accepted), 32'(FIFO_DEPTH + 1));
        chk("fifo_full_ready", 32'(cmd_ready), 32'd0);
        chk("fifo_no_word", 32'(out_valid), 32'd0);
        repeat (30) run_cycle(1'b0, 1'b1);
        expect_fire(32'd0, 32'h40);
        expect_fire(32'd0, 32'h40);
        expect_fire(32'd0, 32'h41);
        expect_fire(32'd3, 32'h42);
        expect_fire(32'd0, 32'h42);
        expect_fire(32'd0, 32'h43);
        expect_fire(32'd0, 32'h43);
        expect_word(32'h01, 32'd2, 32'd1);
        expect_word(32'h01, 32'd1, 32'd1);
        expect_word(32'h16, 32'd5, 32'd1);
        expect_word(32'h03, 32'd2, 32'd1);
        compare_all("fifo");

        // ---------------- reset during a command ----------------
        push_bits(32'hFF, 8);
        start_cmd(8'h60, 1'b1, 7'd20);
        repeat (4) run_cycle(1'b0, 1'b0);
        send_cmd(8'h61, 1'b0, 7'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_dec_en", 32'(dec_en), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("mid_rst_out_valid_hold", 32'(out_valid), 32'd0);
        reset = 1'b0;
        step();
        chk("mid_rst_rel_ready", 32'(cmd_ready), 32'd1);
        seen = 0;
        repeat (5) begin
            if (dec_en) seen = 1;
            step();
        end
        chk("mid_rst_fifo_empty", 32'(seen), 32'd0);
        clear_queues();
        out_ready = 1'b1;
        push_bits(32'h5, 3);
        start_cmd(8'h25, 1'b0, 7'd3);
        repeat (6) run_cycle(1'b0, 1'b1);
        repeat (3) expect_fire(32'd0, 32'h25);
        expect_word(32'h05, 32'd3, 32'd1);
        compare_all("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin_request_sequencer.md
Name: bin_request_sequencer

Overview:
Hardware replacement for the bench-side bin-count control around the arithmetic Decoder.
- Accepts decode commands (pState, bypass flag, bin count) through a buffered valid/ready port.
- Drives the Decoder's per-cycle n_bin/bypass/pState controls and honours its byte-fetch stall.
- Packs the returned bins LSB-first into OUT_W-bit words on a valid/ready output stream, one flushed word group per command.

Parameters:
BIN_WIDTH, 4, max bins decoded per cycle in bypass mode (>=1)
CNT_W, 7, width of per-command bin count
FIFO_DEPTH, 4, command buffer entries (power of 2, >=2)
OUT_W, 8, packed output word width; must be a multiple of BIN_WIDTH

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command buffer not full
cmd_pstate  in  8  context state for the command
cmd_bypass  in  1  1 = bypass bins, 0 = regular (context-coded) bins
cmd_num_bins  in  CNT_W  bins to decode; 0 = discard command
dec_en  out  1  Decoder advances this cycle
dec_pstate  out  8  pState of the active command
dec_bypass  out  1  bypass flag of the active command
dec_n_bin  out  NB_W=max(1,clog2(BIN_WIDTH))  bins this cycle minus 1
dec_stall  in  1  Decoder waiting on a byte; no bins produced this cycle
dec_bin  in  BIN_WIDTH  decoded bins; bits [dec_n_bin:0] valid when fire
out_valid  out  1  packed word available
out_ready  in  1  consumer accepts word
out_data  out  OUT_W  packed bins; first decoded bin at bit 0
out_count  out  clog2(OUT_W+1)  valid bins in out_data (1..OUT_W)
out_last  out  1  final word of a command

Behaviour:
- Reset (async, any time):
  - FIFO empty, state IDLE, accumulator cleared.
  - All outputs 0 except cmd_ready.
  - cmd_ready is 0 while reset is high and 1 the cycle after release.
  - Any in-flight command and its partial word are lost.
- Push: cmd_valid & cmd_ready. cmd_ready = !full, with no same-cycle pass-through, so a full FIFO never accepts even if it pops that cycle.
- FSM: IDLE -> LOAD -> RUN -> IDLE.
  - IDLE: if the FIFO is non-empty, pop the head into active registers (pstate, bypass, rem = num_bins).
  - LOAD: if rem = 0, return to IDLE with no output; otherwise go to RUN. LOAD costs exactly one cycle.
  - RUN: k = bypass ? min(rem, BIN_WIDTH) : 1; dec_n_bin = k-1 (combinational from rem); dec_pstate and dec_bypass come from the active registers and are held stable for the whole command.
- dec_en = RUN & (!out_valid | out_ready).
- fire = dec_en & !dec_stall.
  - On fire: dec_bin[i] -> acc[fill+i] for i < k; fill += k; rem -= k.
  - While dec_stall is high: rem, fill and the decoder controls hold.
- Word emission on a fire edge: when fill+k == OUT_W or rem == k:
  - the word moves into the output register: out_valid=1, out_count=fill+k, out_last=(rem==k), upper unused bits 0;
  - fill resets to 0.
  - If rem == k, the FSM goes to IDLE.
- Because each command starts at fill=0 and OUT_W % BIN_WIDTH == 0, a fire never overflows a word.
- Output register:
  - cleared (out_valid=0) on out_valid & out_ready unless reloaded the same edge;
  - out_data, out_count and out_last are stable while out_valid & !out_ready.
- Latency, for an idle block with an empty FIFO: push at edge N -> pop at N+1 -> LOAD at N+2 -> first dec_en in cycle after N+2 -> word visible one cycle after the completing fire.
- Back-to-back commands: the next pop occurs in the IDLE cycle after the last fire. The single output register plus dec_en gating guarantees no word loss.

Decomposition:
- Package bin_seq_pkg:
  - state enum (IDLE, LOAD, RUN);
  - NB_W and OUT_CNT_W derivation functions;
  - command struct {pstate[7:0], bypass, num_bins[CNT_W-1:0]}.
- Sub-module cmd_fifo: synchronous FIFO, async active-high reset, parameterised width/depth, with full/empty flags.

Test Plan:
- Regular, BIN_WIDTH=4/OUT_W=8: cmd {0x25,0,3}, bins 1,0,1 -> three fires with dec_n_bin=0, dec_pstate=0x25; one word out_data=0x05, out_count=3, out_last=1.
- Bypass, cmd {0x10,1,10}, all bins 1 -> dec_n_bin 3,3,1; words {0xFF, count 8, last 0} then {0x03, count 2, last 1}.
- Stall: dec_stall high 3 cycles mid-bypass -> dec_n_bin/dec_pstate held, no bins consumed, total bins still 10, data identical to the unstalled run.
- Backpressure: out_ready=0 after the first word -> dec_en drops, out_data stable; releasing out_ready resumes with no lost or duplicated bins.
- FIFO: with out_ready=0, offer 6 commands back to back -> cmd_ready falls after FIFO_DEPTH accepted (plus the one popped). A cmd {0x30,0,0} yields no output word and the following command decodes normally.
- Reset asserted mid-RUN -> next cycle: out_valid=0, dec_en=0, FIFO empty; after release cmd_ready=1 and a fresh cmd {0x25,0,3} reproduces the first scenario.
